mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto a single memory port.
// Alternates grants under contention and aborts accesses that wait too long for mem_ready.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t     state;
  logic       last_fetch;
  logic [7:0] wait_cnt;
  logic [7:0] wait_next;
  logic       fetch_ok;
  logic       grant_data;

  assign fetch_ok   = if_req && !halt;
  // Data wins unless fetch is also eligible and data was granted last.
  assign grant_data = d_req && (!fetch_ok || last_fetch);
  assign wait_next  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

  // NOTE: every register here, state and outputs alike, is updated with <= so all
  // of them see the pre-edge values; the async reset clears everything including rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_fetch <= 1'b1;
      wait_cnt   <= '0;
      if_valid   <= 1'b0;
      if_rdata   <= '0;
      d_valid    <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            state      <= DATA;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            last_fetch <= 1'b0;
            wait_cnt   <= '0;
          end else if (fetch_ok) begin
            state      <= FETCH;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            last_fetch <= 1'b1;
            wait_cnt   <= '0;
          end
        end
        FETCH, DATA: begin
          // A ready arriving on the limit cycle still counts as success.
          if (mem_ready || wait_next >= WAIT_LIMIT) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            err    <= !mem_ready;
            if (state == FETCH) begin
              if_valid <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              d_valid <= 1'b1;
              d_rdata <= mem_ready ? mem_rdata : '0;
            end
          end
          if (!mem_ready) wait_cnt <= wait_next;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
